debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel key debouncer with edge and hold/auto-repeat detection, the successor to the single-key debouncer on the board I/O path. Each of CHANNELS raw push-button inputs is synchronised, filtered for NUMBER stable cycles, and presented as a clean level plus one-cycle press/release pulses. Keys held beyond HOLD_NUMBER cycles raise a hold flag and, optionally, a periodic repeat pulse for single-step and run-control logic.

## Interface
- CHANNELS, 4: number of independent key channels (≥1).
- NUMBER, 24'd10_00: stable cycles required before a level is accepted.
- NBITS, 24: width of debounce counters; NUMBER < 2^NBITS.
- HOLD_NUMBER, 24'd5_000_000: cycles key_o must stay 1 before hold asserts.
- REPEAT_NUMBER, 24'd1_000_000: cycles between repeat pulses while held.
- HBITS, 24: width of hold/repeat counters; HOLD_NUMBER, REPEAT_NUMBER < 2^HBITS.
- REPEAT_EN, 1: 1 enables repeat_o; 0 forces repeat_o to 0.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- key_i  in  CHANNELS  raw asynchronous key levels, 1 = pressed.
- key_o  out  CHANNELS  debounced level.
- press_o  out  CHANNELS  one-cycle pulse on key_o 0→1.
- release_o  out  CHANNELS  one-cycle pulse on key_o 1→0.
- hold_o  out  CHANNELS  level, 1 while key held past HOLD_NUMBER.
- repeat_o  out  CHANNELS  one-cycle pulse at hold entry and every repeat period.

## Operation
- Channels fully independent; no shared state.
- Per channel: 2-FF synchroniser t1←key_i, t2←t1.
- Filter: registered sample m and counter cnt. If t2≠m: m←t2, cnt←0. Else if cnt==NUMBER: key_o←m, cnt holds. Else cnt←cnt+1.
- Any glitch shorter than NUMBER+1 stable cycles restarts cnt; key_o unchanged.
- press_o/release_o registered on the same edge key_o changes; never both in one cycle; never asserted without a key_o change.
- Hold counter hc: 0 whenever key_o is 0 or on the edge key_o falls.
- While key_o==1 and hold_o==0: hc increments; when hc==HOLD_NUMBER: hold_o←1, repeat_o pulses (if REPEAT_EN), hc←0.
- While hold_o==1: hc increments; when hc==REPEAT_NUMBER: repeat_o pulses (if REPEAT_EN), hc←0.
- On the edge key_o falls: hold_o←0, hc←0, repeat_o←0, release_o←1, same edge.
- Counters never wrap: cnt saturates at NUMBER, hc resets at its terminal value.

## Timing
- Reset values: t1, t2, m, key_o, press_o, release_o, hold_o, repeat_o all 0; cnt, hc 0. Asynchronous assert; first update on first posedge after deassert.
- Input change sampled at edge E0 → t2 at E1 → m at E2 → key_o and press_o/release_o at edge E0+NUMBER+3.
- hold_o rises HOLD_NUMBER+1 edges after key_o rises; first repeat_o on that same edge.
- Subsequent repeat_o pulses every REPEAT_NUMBER+1 edges.
- All pulses exactly one clk wide.
- Reset mid-operation: all outputs drop immediately, no release_o emitted. A key held through reset is re-qualified: key_o and press_o at NUMBER+3 edges after reset release.
- Release before hold: hold_o and repeat_o never assert.

## Test plan
- NUMBER=4, key_i[0] 0→1 steady → key_o[0]=1 and press_o[0]=1 for one cycle exactly 7 edges after the sampling edge; other channels stay 0.
- NUMBER=4, key_i[1] toggled with 3-cycle high pulses then steady 0 → key_o[1], press_o[1] never assert.
- NUMBER=4, HOLD_NUMBER=10, REPEAT_NUMBER=5, REPEAT_EN=1, key held 40 cycles → hold_o rises 11 edges after key_o; repeat_o pulses at that edge then every 6 edges; release gives release_o pulse, hold_o=0 same edge.
- Same with REPEAT_EN=0 → hold_o behaves identically, repeat_o constant 0.
- Channels 0 and 2 pressed on the same edge, channel 2 released 3 cycles later → independent, correctly timed pulses; no cross-channel effect.
- rst asserted while key_o[3]=1 and hold_o[3]=1, key still held → outputs 0 immediately, no release_o; after deassert key_o[3] and press_o[3] reassert at NUMBER+3 edges.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: 2-FF sync, NUMBER-cycle stability filter, press/release pulses, hold/auto-repeat.
// key_o follows a stable input after NUMBER+3 clocks; no backpressure, outputs are free-running levels/pulses.
module debounce_multi #(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned NUMBER        = 24'd10_00,
   parameter int unsigned NBITS         = 24,
   parameter int unsigned HOLD_NUMBER   = 24'd5_000_000,
   parameter int unsigned REPEAT_NUMBER = 24'd1_000_000,
   parameter int unsigned HBITS         = 24,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] key_i,
   output logic [CHANNELS-1:0] key_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o,
   output logic [CHANNELS-1:0] hold_o,
   output logic [CHANNELS-1:0] repeat_o
);

   localparam logic [NBITS-1:0] CNT_MAX  = NBITS'(NUMBER);
   localparam logic [HBITS-1:0] HOLD_MAX = HBITS'(HOLD_NUMBER);
   localparam logic [HBITS-1:0] REP_MAX  = HBITS'(REPEAT_NUMBER);

   typedef enum logic [1:0] {
      ST_UP   = 2'd0,
      ST_DOWN = 2'd1,
      ST_HELD = 2'd2
   } key_st_t;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic             t1;
      logic             t2;
      logic             m;
      logic [NBITS-1:0] cnt;
      logic             stable;
      key_st_t          st;
      key_st_t          st_nxt;
      logic [HBITS-1:0] hc;
      logic [HBITS-1:0] hc_nxt;
      logic             press_nxt;
      logic             rel_nxt;
      logic             rep_nxt;
      logic             press_q;
      logic             rel_q;
      logic             rep_q;

      // Synchroniser and stability filter; cnt saturates once the sample has settled.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            t1  <= 1'b0;
            t2  <= 1'b0;
            m   <= 1'b0;
            cnt <= '0;
         end else begin
            t1 <= key_i[g];
            t2 <= t1;
            if (t2 != m) begin
               m   <= t2;
               cnt <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + NBITS'(1);
            end
         end
      end

      assign stable = (t2 == m) && (cnt == CNT_MAX);

      // UP: key_o=0; DOWN: key_o=1 counting to hold; HELD: key_o=1 with hold_o, counting repeats.
      always_comb begin
         st_nxt    = st;
         hc_nxt    = hc;
         press_nxt = 1'b0;
         rel_nxt   = 1'b0;
         rep_nxt   = 1'b0;
         case (st)
            ST_UP: begin
               hc_nxt = '0;
               if (stable && m) begin
                  st_nxt    = ST_DOWN;
                  press_nxt = 1'b1;
               end
            end
            ST_DOWN: begin
               if (stable && !m) begin
                  st_nxt  = ST_UP;
                  rel_nxt = 1'b1;
                  hc_nxt  = '0;
               end else if (hc == HOLD_MAX) begin
                  st_nxt  = ST_HELD;
                  rep_nxt = REPEAT_EN;
                  hc_nxt  = '0;
               end else begin
                  hc_nxt = hc + HBITS'(1);
               end
            end
            ST_HELD: begin
               if (stable && !m) begin
                  st_nxt  = ST_UP;
                  rel_nxt = 1'b1;
                  hc_nxt  = '0;
               end else if (hc == REP_MAX) begin
                  rep_nxt = REPEAT_EN;
                  hc_nxt  = '0;
               end else begin
                  hc_nxt = hc + HBITS'(1);
               end
            end
            default: begin
               st_nxt = ST_UP;
               hc_nxt = '0;
            end
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st      <= ST_UP;
            hc      <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
         end else begin
            st      <= st_nxt;
            hc      <= hc_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
            rep_q   <= rep_nxt;
         end
      end

      assign key_o[g]     = (st != ST_UP);
      assign hold_o[g]    = (st == ST_HELD);
      assign press_o[g]   = press_q;
      assign release_o[g] = rel_q;
      assign repeat_o[g]  = rep_q;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised scoreboard bench for debounce_multi, two instances (repeat enabled / disabled).
module tb_debounce_multi;

   localparam int CH   = 4;
   localparam int NUM  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] key_i = '0;

   logic [CH-1:0] key_a, press_a, rel_a, hold_a, rep_a;
   logic [CH-1:0] key_b, press_b, rel_b, hold_b, rep_b;

   debounce_multi #(
      .CHANNELS(CH), .NUMBER(NUM), .NBITS(8), .HOLD_NUMBER(HOLD),
      .REPEAT_NUMBER(REP), .HBITS(8), .REPEAT_EN(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .key_i(key_i), .key_o(key_a), .press_o(press_a),
      .release_o(rel_a), .hold_o(hold_a), .repeat_o(rep_a)
   );

   debounce_multi #(
      .CHANNELS(CH), .NUMBER(NUM), .NBITS(8), .HOLD_NUMBER(HOLD),
      .REPEAT_NUMBER(REP), .HBITS(8), .REPEAT_EN(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .key_i(key_i), .key_o(key_b), .press_o(press_b),
      .release_o(rel_b), .hold_o(hold_b), .repeat_o(rep_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] key;
      logic [CH-1:0] press;
      logic [CH-1:0] rel;
      logic [CH-1:0] hold;
      logic [CH-1:0] rep;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
      end
   endtask

   // Reference model: key_o takes a value once the sampled input has held it for the
   // NUMBER+2 samples ending two edges ago; hold/repeat follow from the edge count since key_o rose.
   initial begin : model
      logic [CH-1:0] hist[$];
      logic [CH-1:0] mk;
      int            rise[CH];
      int            en;
      exp_t          e;
      mk = '0;
      en = 0;
      for (int c = 0; c < CH; c++) rise[c] = 0;
      forever begin
         @(posedge clk);
         cyc++;
         e = '0;
         if (rst) begin
            hist.delete();
            repeat (3) hist.push_back('0);
            mk = '0;
         end else begin
            en++;
            hist.push_back(key_i);
            if (hist.size() > NUM + 4) void'(hist.pop_front());
            for (int c = 0; c < CH; c++) begin
               logic nk;
               logic same;
               int   t;
               nk = mk[c];
               if (hist.size() == NUM + 4) begin
                  same = 1'b1;
                  for (int i = 1; i <= NUM + 1; i++)
                     if (hist[i][c] != hist[0][c]) same = 1'b0;
                  if (same) nk = hist[0][c];
               end
               e.key[c]   = nk;
               e.press[c] = nk & ~mk[c];
               e.rel[c]   = mk[c] & ~nk;
               if (e.press[c]) rise[c] = en;
               if (mk[c] && nk) begin
                  t = en - rise[c];
                  e.hold[c] = (t >= HOLD + 1);
                  e.rep[c]  = (t >= HOLD + 1) && (((t - HOLD - 1) % (REP + 1)) == 0);
               end
               mk[c] = nk;
            end
         end
         exp_q.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("key_o_a",     32'(key_a),   32'(e.key));
            chk("press_o_a",   32'(press_a), 32'(e.press));
            chk("release_o_a", 32'(rel_a),   32'(e.rel));
            chk("hold_o_a",    32'(hold_a),  32'(e.hold));
            chk("repeat_o_a",  32'(rep_a),   32'(e.rep));
            chk("key_o_b",     32'(key_b),   32'(e.key));
            chk("press_o_b",   32'(press_b), 32'(e.press));
            chk("release_o_b", 32'(rel_b),   32'(e.rel));
            chk("hold_o_b",    32'(hold_b),  32'(e.hold));
            chk("repeat_o_b",  32'(rep_b),   32'(0));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin : stim
      int e0, n, m;
      bit found;

      tick(3);
      chk("reset_outputs_a", 32'({key_a, press_a, rel_a, hold_a, rep_a}), 32'(0));
      rst = 1'b0;
      tick(12);

      // Single press on channel 0: press latency, then hold latency.
      key_i[0] = 1'b1;
      e0 = cyc + 1;
      found = 1'b0;
      n = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (press_a[0]) begin found = 1'b1; n = cyc; end
      end
      chk("press0_seen", 32'(found), 32'(1));
      chk("press0_latency", 32'(n - e0), 32'(NUM + 3));
      found = 1'b0;
      m = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (hold_a[0]) begin found = 1'b1; m = cyc; end
      end
      chk("hold0_seen", 32'(found), 32'(1));
      chk("hold0_latency", 32'(m - n), 32'(HOLD + 1));
      tick(40 - (m - n));
      key_i[0] = 1'b0;
      tick(15);

      // Short glitches on channel 1 must never qualify.
      repeat (4) begin
         key_i[1] = 1'b1;
         tick(3);
         key_i[1] = 1'b0;
         tick(3);
      end
      tick(12);

      // Channels 0 and 2 together, channel 2 released shortly after qualifying.
      key_i[0] = 1'b1;
      key_i[2] = 1'b1;
      tick(NUM + 4 + 3);
      key_i[2] = 1'b0;
      tick(25);
      key_i[0] = 1'b0;
      tick(15);

      // Reset while channel 3 is held; key stays down through reset.
      key_i[3] = 1'b1;
      tick(NUM + 3 + HOLD + 6);
      chk("pre_reset_hold3", 32'(hold_a[3]), 32'(1));
      rst = 1'b1;
      #1;
      chk("async_reset_outputs_a", 32'({key_a, press_a, rel_a, hold_a, rep_a}), 32'(0));
      chk("async_reset_outputs_b", 32'({key_b, press_b, rel_b, hold_b, rep_b}), 32'(0));
      tick(2);
      rst = 1'b0;
      e0 = cyc + 1;
      found = 1'b0;
      n = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (press_a[3]) begin found = 1'b1; n = cyc; end
      end
      chk("press3_after_reset_seen", 32'(found), 32'(1));
      chk("press3_after_reset_latency", 32'(n - e0), 32'(NUM + 3));
      tick(10);
      key_i[3] = 1'b0;
      tick(15);

      // Randomised traffic: fast toggling, then slow toggling, with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         tick(1);
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, (i < 800) ? 3 : 24) == 0) key_i[c] = ~key_i[c];
         if (rst) rst = ($urandom_range(0, 1) == 0);
         else     rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
